// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C receive path: assembler state encoding
// and byte/statistics widths.
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam int I2C_STAT_W = 16;

  typedef enum logic [1:0] {
    ASM_IDLE  = 2'd0,
    ASM_SHIFT = 2'd1,
    ASM_FULL  = 2'd2,
    ASM_BAD   = 2'd3
  } asm_state_t;

endpackage

// File: rtl/i2c_byte_fifo.sv
// DEPTH x 8 synchronous FIFO with registered first-word-fall-through head,
// synchronous clear, occupancy count and full flag.
module i2c_byte_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [I2C_BYTE_W-1:0] wdata,
  input  logic                  pop,
  output logic [I2C_BYTE_W-1:0] rdata,
  output logic                  valid,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  accepted
);

  logic [I2C_BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W-1:0]     rd_next;
  logic [ADDR_W:0]       count_next;
  logic                  do_pop;
  logic                  do_push;

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign do_pop     = pop && valid;
  assign do_push    = push && (!full || do_pop);
  assign accepted   = do_push;
  assign rd_next    = rd_ptr + ADDR_W'(do_pop);
  assign count_next = count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      rdata  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      valid  <= (count_next != '0);
      full   <= (count_next == (ADDR_W+1)'(DEPTH));
      // New head is either the byte being written into the head slot or memory.
      if (do_push || do_pop)
        rdata <= (do_push && (wr_ptr == rd_next)) ? wdata : mem[rd_next];
    end
  end

endmodule

// File: rtl/i2c_master_rx_fifo.sv
// Serial-to-byte assembler feeding a small FIFO; drops and flags malformed,
// errored and overflowing bytes. Optional statistics under I2C_RX_STATS_EN.
module i2c_master_rx_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  bit_data,
  input  logic                  bit_load,
  input  logic                  byte_finish,
  input  logic                  byte_error,
  input  logic                  clear,
  output logic [I2C_BYTE_W-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  overflow,
  output logic                  frame_error,
`ifdef I2C_RX_STATS_EN
  output logic [I2C_STAT_W-1:0] byte_count,
  output logic [I2C_STAT_W-1:0] drop_count,
`endif
  output logic [1:0]            asm_state
);

  asm_state_t            state, state_l, state_n;
  logic [3:0]            bit_cnt, cnt_l, cnt_n;
  logic [I2C_BYTE_W-1:0] shift, shift_l;
  logic                  push_req;
  logic                  frame_drop;
  logic                  accepted;
  logic                  ovf_drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ASM_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (clear) begin
      state   <= ASM_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      shift   <= shift_l;
    end
  end

  // The load is applied first; finish then judges the post-load state.
  always_comb begin
    state_l = state;
    cnt_l   = bit_cnt;
    shift_l = shift;
    if (bit_load) begin
      shift_l = {shift[I2C_BYTE_W-2:0], bit_data};
      cnt_l   = (bit_cnt > 4'd8) ? bit_cnt : bit_cnt + 4'd1;
      unique case (state)
        ASM_IDLE:  state_l = ASM_SHIFT;
        ASM_SHIFT: state_l = (cnt_l == 4'd8) ? ASM_FULL : ASM_SHIFT;
        ASM_FULL:  state_l = ASM_BAD;
        ASM_BAD:   state_l = ASM_BAD;
        default:   state_l = ASM_BAD;
      endcase
    end
    push_req   = byte_finish && (state_l == ASM_FULL) && !byte_error;
    frame_drop = byte_finish && !push_req;
    state_n    = byte_finish ? ASM_IDLE : state_l;
    cnt_n      = byte_finish ? 4'd0 : cnt_l;
  end

  assign asm_state = state;
  assign ovf_drop  = push_req && !accepted;

  i2c_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .push     (push_req),
    .wdata    (shift_l),
    .pop      (rd_ready),
    .rdata    (rd_data),
    .valid    (rd_valid),
    .count    (count),
    .full     (full),
    .accepted (accepted)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else if (clear) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (ovf_drop)   overflow    <= 1'b1;
      if (frame_drop) frame_error <= 1'b1;
    end
  end

`ifdef I2C_RX_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_count <= '0;
      drop_count <= '0;
    end else if (clear) begin
      byte_count <= '0;
      drop_count <= '0;
    end else begin
      if (accepted && byte_count != '1) byte_count <= byte_count + 1'b1;
      if ((ovf_drop || frame_drop) && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_master_rx_fifo.sv
// Scoreboard bench for i2c_master_rx_fifo: serial byte driver, FIFO model
// with expected queue, sticky flag model and a final report.
module tb_i2c_master_rx_fifo;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset_n;
  logic       bit_data;
  logic       bit_load;
  logic       byte_finish;
  logic       byte_error;
  logic       clear;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] count;
  logic       full;
  logic       overflow;
  logic       frame_error;
  logic [1:0] asm_state;
`ifdef I2C_RX_STATS_EN
  logic [15:0] byte_count;
  logic [15:0] drop_count;
`endif

  i2c_master_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bit_data    (bit_data),
    .bit_load    (bit_load),
    .byte_finish (byte_finish),
    .byte_error  (byte_error),
    .clear       (clear),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .frame_error (frame_error),
`ifdef I2C_RX_STATS_EN
    .byte_count  (byte_count),
    .drop_count  (drop_count),
`endif
    .asm_state   (asm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic       exp_ovf;
  logic       exp_ferr;
  int         exp_bytes;
  int         exp_drops;
  int         tests_run;
  int         tests_failed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf   = 1'b0;
    exp_ferr  = 1'b0;
    exp_bytes = 0;
    exp_drops = 0;
  endtask

  task automatic model_finish(input logic [7:0] val, input int nloads, input logic err);
    if (nloads == 8 && !err) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(val);
        exp_bytes++;
      end else begin
        exp_ovf = 1'b1;
        exp_drops++;
      end
    end else begin
      exp_ferr = 1'b1;
      exp_drops++;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
    check({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_ferr"}, 32'(frame_error), 32'(exp_ferr));
  endtask

  task automatic load_bit(input logic b);
    bit_data = b;
    bit_load = 1'b1;
    tick();
    bit_load = 1'b0;
  endtask

  // Sends nloads bits of val MSB first (zeros beyond 8), then finish.
  // same_cycle puts finish on the last load; with_pop pops the head on the finish edge.
  task automatic send_byte(input logic [7:0] val, input int nloads, input logic err,
                           input logic same_cycle, input logic with_pop);
    logic [7:0] v;
    v = val;
    for (int i = 0; i < nloads; i++) begin
      bit_data = (i < 8) ? v[7-i] : 1'b0;
      bit_load = 1'b1;
      if (same_cycle && i == nloads - 1) begin
        byte_finish = 1'b1;
        byte_error  = err;
      end else begin
        tick();
        bit_load = 1'b0;
      end
    end
    if (!same_cycle) begin
      byte_finish = 1'b1;
      byte_error  = err;
    end
    if (with_pop) begin
      if (exp_q.size() == 0) check("pop_empty", 32'(rd_valid), 32'd0);
      else check("pop_head", 32'(rd_data), 32'(exp_q.pop_front()));
      rd_ready = 1'b1;
    end
    model_finish(val, nloads, err);
    tick();
    bit_load    = 1'b0;
    byte_finish = 1'b0;
    byte_error  = 1'b0;
    rd_ready    = 1'b0;
  endtask

  task automatic pop_check();
    int w;
    w = 0;
    while (!rd_valid && w < 20) begin
      tick();
      w++;
    end
    if (!rd_valid) begin
      check("rd_valid_timeout", 32'(rd_valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      check("unexpected_data", 32'(rd_valid), 32'd0);
    end else begin
      check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'h00);
    check({tag, "_asm_state"}, 32'(asm_state), 32'd0);
    check_status(tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    bit_data     = 1'b0;
    bit_load     = 1'b0;
    byte_finish  = 1'b0;
    byte_error   = 1'b0;
    clear        = 1'b0;
    rd_ready     = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    // single byte and push latency
    send_byte(8'h13, 8, 1'b0, 1'b0, 1'b0);
    check("single_valid", 32'(rd_valid), 32'd1);
    check("single_data", 32'(rd_data), 32'h13);
    check("single_count", 32'(count), 32'd1);
    pop_check();
    check_status("single_after_pop");

    // fill and overflow
    send_byte(8'h13, 8, 1'b0, 1'b0, 1'b0);
    send_byte(8'h57, 8, 1'b0, 1'b0, 1'b0);
    send_byte(8'h9b, 8, 1'b0, 1'b0, 1'b0);
    send_byte(8'hdf, 8, 1'b0, 1'b0, 1'b0);
    send_byte(8'haa, 8, 1'b0, 1'b0, 1'b0);
    check("fill_ovf_expected", 32'(overflow), 32'd1);
    check_status("fill");
    while (exp_q.size() != 0) pop_check();
    check_status("fill_drained");
    pulse_clear();
    check_status("after_clear");

    // push and pop in the same cycle at full
    send_byte(8'h13, 8, 1'b0, 1'b0, 1'b0);
    send_byte(8'h57, 8, 1'b0, 1'b0, 1'b0);
    send_byte(8'h9b, 8, 1'b0, 1'b0, 1'b0);
    send_byte(8'hdf, 8, 1'b0, 1'b0, 1'b0);
    send_byte(8'haa, 8, 1'b0, 1'b0, 1'b1);
    check("pp_count", 32'(count), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd0);
    check("pp_head", 32'(rd_data), 32'h57);
    check_status("pp");
    while (exp_q.size() != 0) pop_check();

    // malformed bytes
    send_byte(8'h0f, 5, 1'b0, 1'b0, 1'b0);
    check("short_ferr", 32'(frame_error), 32'd1);
    check_status("short");
    pulse_clear();
    for (int i = 0; i < 9; i++) load_bit(1'b1);
    check("nine_bad_state", 32'(asm_state), 32'd3);
    byte_finish = 1'b1;
    model_finish(8'hff, 9, 1'b0);
    tick();
    byte_finish = 1'b0;
    check("nine_idle_state", 32'(asm_state), 32'd0);
    check_status("nine");
    pulse_clear();
    send_byte(8'h3c, 8, 1'b1, 1'b0, 1'b0);
    check_status("errored");
    pulse_clear();

    // load and finish on the same cycle
    send_byte(8'hc3, 8, 1'b0, 1'b1, 1'b0);
    check_status("same_cycle");
    pop_check();

    // reset mid-byte
    for (int i = 0; i < 3; i++) load_bit(1'b1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("mid_reset");
    tick();
    reset_n = 1'b1;
    tick();
    send_byte(8'h55, 8, 1'b0, 1'b0, 1'b0);
    check_status("after_reset_55");
    pop_check();

    // clear mid-byte
    for (int i = 0; i < 3; i++) load_bit(1'b1);
    pulse_clear();
    check_reset_values("mid_clear");
    send_byte(8'h55, 8, 1'b0, 1'b0, 1'b0);
    check_status("after_clear_55");
    pop_check();

    // random traffic with occasional malformed bytes and reads
    for (int k = 0; k < 24; k++) begin
      int r;
      int n;
      r = $urandom_range(0, 7);
      n = (r == 0) ? 5 : ((r == 1) ? 9 : 8);
      send_byte(8'($urandom_range(0, 255)), n, (r == 2), 1'($urandom_range(0, 1)), 1'b0);
      check_status("rand");
      if ($urandom_range(0, 2) != 0 && exp_q.size() != 0) pop_check();
    end
`ifdef I2C_RX_STATS_EN
    check("stats_bytes", 32'(byte_count), 32'(exp_bytes));
    check("stats_drops", 32'(drop_count), 32'(exp_drops));
`endif
    while (exp_q.size() != 0) pop_check();
    check_status("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
